// File: rtl/mod_op_sequencer_pkg.sv
// Shared encodings for the modular add/sub command sequencer: FSM states,
// command opcodes and the default modulus.
package mod_op_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_ACC_ADD = 2'b10;
  localparam logic [1:0] OP_ACC_SUB = 2'b11;

  localparam logic [3:0] DEFAULT_M = 4'b1100;

endpackage

// File: rtl/mod_op_sequencer_range_chk.sv
// Combinational range check: ok is high when the 4-bit value is below the modulus.
module mod_range_chk #(
  parameter logic [3:0] M = 4'b1100
) (
  input  logic [3:0] val,
  output logic       ok
);

  assign ok = (val < M);

endmodule

// File: rtl/mod_op_sequencer.sv
// Registered command front-end for the external combinational mod-M adder/subtractor,
// with operand range checks and a running accumulator.
module mod_op_sequencer
  import mod_op_sequencer_pkg::*;
#(
  parameter logic [3:0] M = DEFAULT_M
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_op,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       acc_clr,
  output logic       add_s,
  output logic [3:0] add_x,
  output logic [3:0] add_y,
  input  logic [3:0] add_z,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_z,
  output logic       out_err,
  output logic [3:0] acc
);

  // Handshakes: a command moves on in_valid & in_ready at a rising edge, a
  // result on out_valid & out_ready; neither side may retract a raised valid.
  state_t     state;
  logic       acc_op;
  logic [3:0] x_sel;
  logic       x_ok;
  logic       y_ok;
  logic       z_ok;

  assign x_sel     = in_op[1] ? acc : in_a;
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_RESP);

  mod_range_chk #(.M(M)) u_chk_x (.val(x_sel), .ok(x_ok));
  mod_range_chk #(.M(M)) u_chk_y (.val(in_b),  .ok(y_ok));
  mod_range_chk #(.M(M)) u_chk_z (.val(add_z), .ok(z_ok));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc_op  <= 1'b0;
      add_s   <= 1'b0;
      add_x   <= 4'd0;
      add_y   <= 4'd0;
      out_z   <= 4'd0;
      out_err <= 1'b0;
      acc     <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (x_ok && y_ok) begin
              add_x  <= x_sel;
              add_y  <= in_b;
              add_s  <= in_op[0];
              acc_op <= in_op[1];
              state  <= ST_DRIVE;
            end else begin
              // Out-of-range operand: report immediately, the adder is never driven.
              out_z   <= 4'd0;
              out_err <= 1'b1;
              state   <= ST_RESP;
            end
          end
        end
        ST_DRIVE: begin
          out_z <= add_z;
          if (z_ok) begin
            out_err <= 1'b0;
            if (acc_op) acc <= add_z;
          end else begin
            out_err <= 1'b1;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // Placed last so a clear overrides a same-cycle accumulator write.
      if (acc_clr) acc <= 4'd0;
    end
  end

endmodule

// File: tb/tb_mod_op_sequencer.sv
// Self-checking bench: behavioural mod-12 adder plus a high-level command model,
// directed scenarios followed by randomized commands.
module tb_mod_op_sequencer;
  import mod_op_sequencer_pkg::*;

  localparam logic [3:0] M = 4'd12;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       acc_clr;
  logic       add_s;
  logic [3:0] add_x;
  logic [3:0] add_y;
  logic [3:0] add_z;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_z;
  logic       out_err;
  logic [3:0] acc;

  int checks = 0;
  int errors = 0;

  logic [3:0] macc;
  logic [3:0] m_add_x;
  logic [3:0] m_add_y;
  logic       m_add_s;
  logic       fault_en;
  logic [3:0] fault_val;

  mod_op_sequencer #(.M(M)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .acc_clr  (acc_clr),
    .add_s    (add_s),
    .add_x    (add_x),
    .add_y    (add_y),
    .add_z    (add_z),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_z    (out_z),
    .out_err  (out_err),
    .acc      (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mod-M add/sub on in-range operands, in plain integer arithmetic.
  function automatic logic [3:0] mod_addsub(input logic s, input logic [3:0] x, input logic [3:0] y);
    int r;
    if (!s) r = (int'(x) + int'(y)) % int'(M);
    else    r = (int'(x) - int'(y) + int'(M)) % int'(M);
    return r[3:0];
  endfunction

  always_comb begin
    add_z = mod_addsub(add_s, add_x, add_y);
    if (fault_en) add_z = fault_val;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one command, checks timing, result, accumulator and backpressure behaviour.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input int stall, input bit clr_drive);
    logic [3:0] x;
    logic [3:0] ez;
    logic       eerr;
    bit         valid_path;
    x = op[1] ? macc : a;
    valid_path = (x < M) && (b < M);
    if (valid_path) begin
      ez   = fault_en ? fault_val : mod_addsub(op[0], x, b);
      eerr = (ez >= M);
    end else begin
      ez   = 4'd0;
      eerr = 1'b1;
    end
    check("idle_in_ready", {7'd0, in_ready}, 8'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (valid_path) begin
      check("drive_out_valid", {7'd0, out_valid}, 8'd0);
      check("drive_add_x", {4'd0, add_x}, {4'd0, x});
      check("drive_add_y", {4'd0, add_y}, {4'd0, b});
      check("drive_add_s", {7'd0, add_s}, {7'd0, op[0]});
      m_add_x = x;
      m_add_y = b;
      m_add_s = op[0];
      if (clr_drive) acc_clr = 1'b1;
      @(posedge clk); #1;
      acc_clr = 1'b0;
      if (!eerr && op[1]) macc = ez;
      if (clr_drive) macc = 4'd0;
    end else begin
      check("err_add_x_held", {4'd0, add_x}, {4'd0, m_add_x});
      check("err_add_y_held", {4'd0, add_y}, {4'd0, m_add_y});
    end
    check("resp_out_valid", {7'd0, out_valid}, 8'd1);
    check("resp_in_ready", {7'd0, in_ready}, 8'd0);
    check("resp_out_z", {4'd0, out_z}, {4'd0, ez});
    check("resp_out_err", {7'd0, out_err}, {7'd0, eerr});
    check("resp_acc", {4'd0, acc}, {4'd0, macc});
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_op    = 2'($urandom_range(0, 3));
      in_a     = 4'($urandom_range(0, 15));
      in_b     = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      check("stall_out_valid", {7'd0, out_valid}, 8'd1);
      check("stall_in_ready", {7'd0, in_ready}, 8'd0);
      check("stall_out_z", {4'd0, out_z}, {4'd0, ez});
      check("stall_out_err", {7'd0, out_err}, {7'd0, eerr});
      check("stall_add_x", {4'd0, add_x}, {4'd0, m_add_x});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("done_out_valid", {7'd0, out_valid}, 8'd0);
    check("done_in_ready", {7'd0, in_ready}, 8'd1);
    check("done_acc", {4'd0, acc}, {4'd0, macc});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = OP_ADD;
    in_a      = 4'd0;
    in_b      = 4'd0;
    acc_clr   = 1'b0;
    out_ready = 1'b0;
    fault_en  = 1'b0;
    fault_val = 4'd0;
    macc      = 4'd0;
    m_add_x   = 4'd0;
    m_add_y   = 4'd0;
    m_add_s   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {7'd0, in_ready}, 8'd1);
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_out_z", {4'd0, out_z}, 8'd0);
    check("rst_out_err", {7'd0, out_err}, 8'd0);
    check("rst_acc", {4'd0, acc}, 8'd0);
    check("rst_add_x", {4'd0, add_x}, 8'd0);
    check("rst_add_y", {4'd0, add_y}, 8'd0);
    check("rst_add_s", {7'd0, add_s}, 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain add/sub, then the accumulator chain including wrap
    run_cmd(OP_ADD, 4'd7, 4'd9, 0, 1'b0);
    run_cmd(OP_SUB, 4'd3, 4'd5, 0, 1'b0);
    run_cmd(OP_ACC_ADD, 4'd0, 4'd11, 0, 1'b0);
    run_cmd(OP_ACC_SUB, 4'd0, 4'd11, 0, 1'b0);
    run_cmd(OP_ACC_SUB, 4'd0, 4'd1, 0, 1'b0);
    check("chain_acc_wrap", {4'd0, acc}, 8'd11);

    // Range error, then a faulty adder result
    run_cmd(OP_ADD, 4'd12, 4'd0, 0, 1'b0);
    run_cmd(OP_SUB, 4'd2, 4'd15, 1, 1'b0);
    fault_en  = 1'b1;
    fault_val = 4'd13;
    run_cmd(OP_ACC_ADD, 4'd0, 4'd1, 0, 1'b0);
    fault_en  = 1'b0;
    check("fault_acc_kept", {4'd0, acc}, 8'd11);

    // Backpressure, then clear coinciding with an accumulator capture
    run_cmd(OP_ADD, 4'd5, 4'd6, 5, 1'b0);
    run_cmd(OP_ACC_ADD, 4'd0, 4'd3, 0, 1'b1);
    check("clr_wins_acc", {4'd0, acc}, 8'd0);

    // Reset during DRIVE aborts the operation and clears acc
    run_cmd(OP_ACC_ADD, 4'd0, 4'd7, 0, 1'b0);
    in_valid = 1'b1;
    in_op    = OP_ACC_ADD;
    in_b     = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_abort_in_ready", {7'd0, in_ready}, 8'd0);
    rst_n = 1'b0;
    #2;
    check("abort_in_ready", {7'd0, in_ready}, 8'd1);
    check("abort_out_valid", {7'd0, out_valid}, 8'd0);
    check("abort_acc", {4'd0, acc}, 8'd0);
    check("abort_add_x", {4'd0, add_x}, 8'd0);
    macc    = 4'd0;
    m_add_x = 4'd0;
    m_add_y = 4'd0;
    m_add_s = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(OP_ADD, 4'd10, 4'd4, 0, 1'b0);

    // Randomized commands, occasionally out of range, with random backpressure
    for (int n = 0; n < 40; n++) begin
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 13)),
              4'($urandom_range(0, 13)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
